// File: rtl/mem_request_arbiter_if.sv
// Bundles the requester and memory-controller handshake signals of mem_request_arbiter.
// The master modport drives requests and controller responses; the slave modport is the arbiter.
interface mem_request_arbiter_if;
    logic        flush_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        ld_req_in;
    logic [31:0] ld_addr_in;
    logic [2:0]  ld_width_in;
    logic        st_req_in;
    logic [31:0] st_addr_in;
    logic [2:0]  st_width_in;
    logic [31:0] st_data_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ld_done_out;
    logic [31:0] ld_data_out;
    logic        st_done_out;
    logic        mc_enable_out;
    logic        mc_rw_out;
    logic [31:0] mc_addr_out;
    logic [2:0]  mc_width_out;
    logic [31:0] mc_wdata_out;
    logic        mc_done_in;
    logic [31:0] mc_rdata_in;

    modport master (
        output flush_in, if_req_in, if_addr_in,
        output ld_req_in, ld_addr_in, ld_width_in,
        output st_req_in, st_addr_in, st_width_in, st_data_in,
        output mc_done_in, mc_rdata_in,
        input  if_done_out, if_data_out, ld_done_out, ld_data_out, st_done_out,
        input  mc_enable_out, mc_rw_out, mc_addr_out, mc_width_out, mc_wdata_out
    );

    modport slave (
        input  flush_in, if_req_in, if_addr_in,
        input  ld_req_in, ld_addr_in, ld_width_in,
        input  st_req_in, st_addr_in, st_width_in, st_data_in,
        input  mc_done_in, mc_rdata_in,
        output if_done_out, if_data_out, ld_done_out, ld_data_out, st_done_out,
        output mc_enable_out, mc_rw_out, mc_addr_out, mc_width_out, mc_wdata_out
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// Arbitrates fetch/load/store requests onto a single byte-serial memory controller,
// holding each granted request until completion and returning a one-cycle done pulse.
module mem_request_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic                   clk_in,
    input logic                   rst_in,
    mem_request_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        OWN_IF,
        OWN_LD,
        OWN_ST
    } owner_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;

    logic             if_ok;
    logic             ld_ok;
    logic             st_ok;
    logic             grant_any;
    owner_t           grant_owner;
    logic [31:0]      grant_addr;
    logic [2:0]       grant_width;
    logic [31:0]      grant_wdata;
    logic             flush_owner;

    function automatic logic width_legal(input logic [2:0] w);
        return (w == 3'b001) || (w == 3'b010) || (w == 3'b100);
    endfunction

    // A flush removes the speculative requesters (fetch, load) from arbitration; stores are architectural.
    assign if_ok = bus.if_req_in && !bus.flush_in;
    assign ld_ok = bus.ld_req_in && !bus.flush_in && width_legal(bus.ld_width_in);
    assign st_ok = bus.st_req_in && width_legal(bus.st_width_in);

    assign flush_owner = bus.flush_in && (owner != OWN_ST);

    always_comb begin
        grant_any   = 1'b0;
        grant_owner = OWN_IF;
        grant_addr  = 32'h0;
        grant_width = 3'b000;
        grant_wdata = 32'h0;
        if (if_ok && (starve_cnt == LIMIT)) begin
            grant_any   = 1'b1;
            grant_owner = OWN_IF;
            grant_addr  = bus.if_addr_in;
            grant_width = 3'b100;
        end else if (st_ok) begin
            grant_any   = 1'b1;
            grant_owner = OWN_ST;
            grant_addr  = bus.st_addr_in;
            grant_width = bus.st_width_in;
            grant_wdata = bus.st_data_in;
        end else if (ld_ok) begin
            grant_any   = 1'b1;
            grant_owner = OWN_LD;
            grant_addr  = bus.ld_addr_in;
            grant_width = bus.ld_width_in;
        end else if (if_ok) begin
            grant_any   = 1'b1;
            grant_owner = OWN_IF;
            grant_addr  = bus.if_addr_in;
            grant_width = 3'b100;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            owner             <= OWN_IF;
            starve_cnt        <= '0;
            bus.if_done_out   <= 1'b0;
            bus.ld_done_out   <= 1'b0;
            bus.st_done_out   <= 1'b0;
            bus.if_data_out   <= 32'h0;
            bus.ld_data_out   <= 32'h0;
            bus.mc_enable_out <= 1'b0;
            bus.mc_rw_out     <= 1'b0;
            bus.mc_addr_out   <= 32'h0;
            bus.mc_width_out  <= 3'b000;
            bus.mc_wdata_out  <= 32'h0;
        end else begin
            bus.if_done_out <= 1'b0;
            bus.ld_done_out <= 1'b0;
            bus.st_done_out <= 1'b0;

            // Fetch only counts as starved while it is actually asking.
            if (!bus.if_req_in) begin
                starve_cnt <= '0;
            end else if ((state == IDLE) && grant_any) begin
                if (grant_owner == OWN_IF) begin
                    starve_cnt <= '0;
                end else if (starve_cnt < LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state             <= BUSY;
                        owner             <= grant_owner;
                        bus.mc_enable_out <= 1'b1;
                        bus.mc_rw_out     <= (grant_owner == OWN_ST);
                        bus.mc_addr_out   <= grant_addr;
                        bus.mc_width_out  <= grant_width;
                        bus.mc_wdata_out  <= grant_wdata;
                    end
                end

                BUSY: begin
                    if (bus.mc_done_in) begin
                        state             <= IDLE;
                        bus.mc_enable_out <= 1'b0;
                        if (!flush_owner) begin
                            case (owner)
                                OWN_IF: begin
                                    bus.if_done_out <= 1'b1;
                                    bus.if_data_out <= bus.mc_rdata_in;
                                end
                                OWN_LD: begin
                                    bus.ld_done_out <= 1'b1;
                                    bus.ld_data_out <= bus.mc_rdata_in;
                                end
                                default: bus.st_done_out <= 1'b1;
                            endcase
                        end
                    end else if (flush_owner) begin
                        state <= DRAIN;
                    end
                end

                // The controller cannot be abandoned mid byte-sequence, so wait it out silently.
                DRAIN: begin
                    if (bus.mc_done_in) begin
                        state             <= IDLE;
                        bus.mc_enable_out <= 1'b0;
                    end
                end

                default: begin
                    state             <= IDLE;
                    bus.mc_enable_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed testbench for mem_request_arbiter: stands in for the requesters and the memory
// controller, stepping through hand-computed scenarios one clock at a time.
module tb_mem_request_arbiter;

    logic clk_in;
    logic rst_in;
    int   checks;
    int   errors;

    mem_request_arbiter_if bus ();

    mem_request_arbiter #(
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Holds the current inputs across n rising edges, then settles just past the last edge.
    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
        end
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_in          = 1'b1;
        bus.flush_in    = 1'b0;
        bus.if_req_in   = 1'b0;
        bus.if_addr_in  = 32'h0;
        bus.ld_req_in   = 1'b0;
        bus.ld_addr_in  = 32'h0;
        bus.ld_width_in = 3'b100;
        bus.st_req_in   = 1'b0;
        bus.st_addr_in  = 32'h0;
        bus.st_width_in = 3'b001;
        bus.st_data_in  = 32'h0;
        bus.mc_done_in  = 1'b0;
        bus.mc_rdata_in = 32'h0;

        $display("[TB] reset");
        apply_stimulus(2);
        check_output("rst_enable", 32'(bus.mc_enable_out), 32'h0);
        check_output("rst_rw",     32'(bus.mc_rw_out),     32'h0);
        check_output("rst_addr",   bus.mc_addr_out,        32'h0);
        check_output("rst_width",  32'(bus.mc_width_out),  32'h0);
        check_output("rst_wdata",  bus.mc_wdata_out,       32'h0);
        check_output("rst_dones",  32'({bus.if_done_out, bus.ld_done_out, bus.st_done_out}), 32'h0);
        check_output("rst_ifdata", bus.if_data_out,        32'h0);
        check_output("rst_lddata", bus.ld_data_out,        32'h0);
        rst_in = 1'b0;
        apply_stimulus(1);

        $display("[TB] single fetch");
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h0000_0100;
        apply_stimulus(1);
        check_output("f1_enable", 32'(bus.mc_enable_out), 32'h1);
        check_output("f1_addr",   bus.mc_addr_out,        32'h0000_0100);
        check_output("f1_width",  32'(bus.mc_width_out),  32'h4);
        check_output("f1_rw",     32'(bus.mc_rw_out),     32'h0);
        apply_stimulus(3);
        check_output("f1_hold",   32'(bus.mc_enable_out), 32'h1);
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'h0000_0513;
        apply_stimulus(1);
        check_output("f1_done",   32'(bus.if_done_out),   32'h1);
        check_output("f1_data",   bus.if_data_out,        32'h0000_0513);
        check_output("f1_en_off", 32'(bus.mc_enable_out), 32'h0);
        bus.mc_done_in = 1'b0;
        bus.if_req_in  = 1'b0;
        apply_stimulus(1);
        check_output("f1_pulse",  32'(bus.if_done_out),   32'h0);

        $display("[TB] simultaneous requests");
        bus.if_req_in   = 1'b1;
        bus.if_addr_in  = 32'h0000_0200;
        bus.ld_req_in   = 1'b1;
        bus.ld_addr_in  = 32'h0000_1000;
        bus.ld_width_in = 3'b100;
        bus.st_req_in   = 1'b1;
        bus.st_addr_in  = 32'h0000_2000;
        bus.st_width_in = 3'b001;
        bus.st_data_in  = 32'h0000_00AB;
        apply_stimulus(1);
        check_output("s_st_rw",    32'(bus.mc_rw_out),    32'h1);
        check_output("s_st_addr",  bus.mc_addr_out,       32'h0000_2000);
        check_output("s_st_width", 32'(bus.mc_width_out), 32'h1);
        check_output("s_st_wdata", bus.mc_wdata_out,      32'h0000_00AB);
        bus.mc_done_in = 1'b1;
        apply_stimulus(1);
        check_output("s_st_done",  32'(bus.st_done_out),  32'h1);
        check_output("s_gap",      32'(bus.mc_enable_out), 32'h0);
        bus.mc_done_in = 1'b0;
        bus.st_req_in  = 1'b0;
        apply_stimulus(1);
        check_output("s_ld_en",    32'(bus.mc_enable_out), 32'h1);
        check_output("s_ld_rw",    32'(bus.mc_rw_out),    32'h0);
        check_output("s_ld_addr",  bus.mc_addr_out,       32'h0000_1000);
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'hDEAD_BEEF;
        apply_stimulus(1);
        check_output("s_ld_done",  32'(bus.ld_done_out),  32'h1);
        check_output("s_ld_data",  bus.ld_data_out,       32'hDEAD_BEEF);
        bus.mc_done_in = 1'b0;
        bus.ld_req_in  = 1'b0;
        apply_stimulus(1);
        check_output("s_if_rw",    32'(bus.mc_rw_out),    32'h0);
        check_output("s_if_addr",  bus.mc_addr_out,       32'h0000_0200);
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'h0000_0013;
        apply_stimulus(1);
        check_output("s_if_done",  32'(bus.if_done_out),  32'h1);
        bus.mc_done_in = 1'b0;
        bus.if_req_in  = 1'b0;
        apply_stimulus(1);

        $display("[TB] starvation");
        bus.if_addr_in = 32'h0000_0600;
        bus.if_req_in  = 1'b1;
        bus.st_req_in  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1);
            check_output($sformatf("starve_st_rw_%0d", i), 32'(bus.mc_rw_out), 32'h1);
            bus.mc_done_in = 1'b1;
            apply_stimulus(1);
            check_output($sformatf("starve_st_done_%0d", i), 32'(bus.st_done_out), 32'h1);
            bus.mc_done_in = 1'b0;
        end
        apply_stimulus(1);
        check_output("starve_if_en",   32'(bus.mc_enable_out), 32'h1);
        check_output("starve_if_rw",   32'(bus.mc_rw_out),     32'h0);
        check_output("starve_if_addr", bus.mc_addr_out,        32'h0000_0600);
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'h0000_0093;
        apply_stimulus(1);
        check_output("starve_if_done", 32'(bus.if_done_out),   32'h1);
        check_output("starve_if_data", bus.if_data_out,        32'h0000_0093);
        bus.mc_done_in = 1'b0;
        bus.if_req_in  = 1'b0;
        apply_stimulus(1);
        check_output("starve_resume",  32'(bus.mc_rw_out),     32'h1);
        bus.mc_done_in = 1'b1;
        apply_stimulus(1);
        check_output("starve_res_done", 32'(bus.st_done_out),  32'h1);
        bus.mc_done_in = 1'b0;
        bus.st_req_in  = 1'b0;
        apply_stimulus(1);

        $display("[TB] flush during load");
        bus.ld_req_in   = 1'b1;
        bus.ld_addr_in  = 32'h0000_3000;
        bus.ld_width_in = 3'b010;
        apply_stimulus(1);
        check_output("fl_ld_addr",  bus.mc_addr_out,       32'h0000_3000);
        check_output("fl_ld_width", 32'(bus.mc_width_out), 32'h2);
        bus.st_req_in = 1'b1;
        apply_stimulus(1);
        bus.flush_in = 1'b1;
        apply_stimulus(1);
        bus.flush_in  = 1'b0;
        bus.ld_req_in = 1'b0;
        check_output("fl_hold0",    32'(bus.mc_enable_out), 32'h1);
        apply_stimulus(1);
        check_output("fl_hold1",    32'(bus.mc_enable_out), 32'h1);
        check_output("fl_hold_addr", bus.mc_addr_out,       32'h0000_3000);
        apply_stimulus(1);
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'h0000_0055;
        apply_stimulus(1);
        check_output("fl_no_done",  32'(bus.ld_done_out),   32'h0);
        check_output("fl_en_off",   32'(bus.mc_enable_out), 32'h0);
        check_output("fl_data_keep", bus.ld_data_out,       32'hDEAD_BEEF);
        bus.mc_done_in = 1'b0;
        apply_stimulus(1);
        check_output("fl_st_grant", 32'(bus.mc_rw_out),     32'h1);
        check_output("fl_st_addr",  bus.mc_addr_out,        32'h0000_2000);

        $display("[TB] flush during store");
        bus.flush_in = 1'b1;
        apply_stimulus(1);
        bus.flush_in = 1'b0;
        check_output("fs_hold",     32'(bus.mc_enable_out), 32'h1);
        bus.mc_done_in = 1'b1;
        apply_stimulus(1);
        check_output("fs_st_done",  32'(bus.st_done_out),   32'h1);
        bus.mc_done_in = 1'b0;
        bus.st_req_in  = 1'b0;
        apply_stimulus(1);
        check_output("fs_pulse",    32'(bus.st_done_out),   32'h0);

        $display("[TB] flush with done on fetch");
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h0000_0400;
        apply_stimulus(1);
        check_output("fd_addr",     bus.mc_addr_out,        32'h0000_0400);
        bus.flush_in    = 1'b1;
        bus.mc_done_in  = 1'b1;
        bus.mc_rdata_in = 32'h0000_0077;
        apply_stimulus(1);
        check_output("fd_no_done",  32'(bus.if_done_out),   32'h0);
        check_output("fd_en_off",   32'(bus.mc_enable_out), 32'h0);
        check_output("fd_data",     bus.if_data_out,        32'h0000_0093);
        bus.mc_done_in = 1'b0;
        bus.if_req_in  = 1'b0;
        bus.ld_req_in  = 1'b1;
        bus.ld_width_in = 3'b100;
        bus.if_req_in  = 1'b1;
        apply_stimulus(1);
        check_output("idle_flush",  32'(bus.mc_enable_out), 32'h0);
        bus.flush_in  = 1'b0;
        bus.if_req_in = 1'b0;
        bus.ld_req_in = 1'b0;
        apply_stimulus(1);

        $display("[TB] reset mid-busy");
        bus.ld_req_in   = 1'b1;
        bus.ld_addr_in  = 32'h0000_5000;
        bus.ld_width_in = 3'b100;
        apply_stimulus(1);
        check_output("rb_grant",    bus.mc_addr_out,        32'h0000_5000);
        rst_in = 1'b1;
        apply_stimulus(1);
        check_output("rb_enable",   32'(bus.mc_enable_out), 32'h0);
        check_output("rb_dones",    32'({bus.if_done_out, bus.ld_done_out, bus.st_done_out}), 32'h0);
        check_output("rb_addr",     bus.mc_addr_out,        32'h0);
        check_output("rb_lddata",   bus.ld_data_out,        32'h0);
        rst_in         = 1'b0;
        bus.ld_req_in  = 1'b0;
        bus.mc_done_in = 1'b1;
        apply_stimulus(1);
        check_output("rb_late_done", 32'(bus.ld_done_out),  32'h0);
        check_output("rb_late_en",  32'(bus.mc_enable_out), 32'h0);
        bus.mc_done_in  = 1'b0;
        bus.ld_req_in   = 1'b1;
        bus.ld_width_in = 3'b011;
        apply_stimulus(2);
        check_output("illegal_w",   32'(bus.mc_enable_out), 32'h0);
        bus.ld_req_in = 1'b0;
        apply_stimulus(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
